// File: rtl/cla_operand_stage.sv
// -----------------------------------------------------------------------------
// cla_operand_stage
//   Registered valid/ready input stage feeding an N-bit carry lookahead adder.
//   Operand pairs (a, b, c_in) are captured from the producer and presented,
//   held stable, on the m_* outputs. The adder's a/b/c_in connect straight to
//   m_a/m_b/m_c_in. A 2-entry skid buffer (main + skid) absorbs back-pressure
//   so that s_ready comes from a register and full throughput is kept.
//
// Ports
//   clk      in   1  single clock, rising edge
//   rst_n    in   1  synchronous active-low reset (priority over everything)
//   flush    in   1  synchronous discard of all buffered operands
//   s_valid  in   1  producer: operand pair valid
//   s_ready  out  1  stage can accept (registered)
//   s_a      in   N  operand A
//   s_b      in   N  operand B
//   s_c_in   in   1  carry-in
//   m_valid  out  1  operands presented to the adder are valid
//   m_ready  in   1  consumer accepts the adder result this cycle
//   m_a      out  N  operand A to adder
//   m_b      out  N  operand B to adder
//   m_c_in   out  1  carry-in to adder
// -----------------------------------------------------------------------------
module cla_operand_stage #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [N-1:0] s_a,
   input  logic [N-1:0] s_b,
   input  logic         s_c_in,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [N-1:0] m_a,
   output logic [N-1:0] m_b,
   output logic         m_c_in
);

   // The downstream adder is built from 4-bit lookahead groups.
   generate
      if ((N % 4 != 0) || (N < 4)) begin : g_bad_width
         $fatal(1, "cla_operand_stage: N must be a multiple of 4 and at least 4");
      end
   endgenerate

   localparam int W = 2 * N + 1;

   // Encoding chosen so that bit 1 is m_valid and bit 0 is "not ready":
   // both handshake outputs come straight from state flops.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BUSY  = 2'b10,
      FULL  = 2'b11
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   main_q, main_d;
   logic [W-1:0]   skid_q, skid_d;
   logic [W-1:0]   in_pair;

   assign in_pair = {s_a, s_b, s_c_in};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      case (state_q)
         EMPTY: begin
            if (s_valid) begin
               main_d  = in_pair;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (s_valid && m_ready) begin
               main_d = in_pair;
            end else if (s_valid) begin
               // Consumer stalled: park the newer pair behind main.
               skid_d  = in_pair;
               state_d = FULL;
            end else if (m_ready) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (m_ready) begin
               main_d  = skid_q;
               state_d = BUSY;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase

      // Flush only empties the buffer; data registers may keep stale values,
      // and any pair accepted this cycle is dropped.
      if (flush) begin
         state_d = EMPTY;
      end
   end

   assign m_valid = state_q[1];
   assign s_ready = ~state_q[0];
   assign {m_a, m_b, m_c_in} = main_q;

endmodule
